fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one syncfifo write port among NREQ requesters using valid/ready handshakes with bounded bursts.
Tracks FIFO occupancy internally so it never issues a write into a full FIFO, including while the FIFO's registered full flag lags.
Drives the FIFO's wr_en/wdata from registered outputs.
Counts write errors reported by the FIFO.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 8, data width; matches FIFO WIDTH
DEPTH, 16, FIFO depth; matches FIFO DEPTH
MAX_BURST, 4, max beats per grant (>=1)
LVL_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  NREQ  per-requester beat valid
in_data  in  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
in_ready  out  NREQ  per-requester accept (combinational)
fifo_wr_en  out  1  registered write strobe to FIFO
fifo_wdata  out  WIDTH  registered write data to FIFO
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  in  1  consumer read strobe (tapped from the FIFO read side)
fifo_wr_err  in  1  FIFO write-error pulse
grant  out  NREQ  one-hot current owner; 0 when no owner
level  out  LVL_W  tracked occupancy
err_cnt  out  8  saturating count of fifo_wr_err pulses

Behaviour:
- Reset: state=ARB, grant=0, rr_ptr=0, beat_cnt=0, level=0, fifo_wr_en=0, fifo_wdata=0, err_cnt=0, in_ready=0. Reset mid-burst aborts the burst; a beat accepted in the reset cycle is dropped.
- FSM states:
  - ARB: no owner, in_ready=0. If any in_valid, select the first valid index searching rr_ptr, rr_ptr+1, ... mod NREQ. Next cycle: GRANT with grant=onehot(sel), beat_cnt=0. Arbitration latency is 1 cycle.
  - GRANT (owner g):
    - in_ready[g] = (level<DEPTH) && !fifo_full; all other in_ready bits are 0.
    - Accept = in_valid[g] && in_ready[g].
- On accept: fifo_wdata<=in_data[g], fifo_wr_en<=1, beat_cnt++, level++. Otherwise fifo_wr_en<=0. Write latency is 1 cycle.
- Burst end, GRANT->ARB next cycle, rr_ptr<=(g+1) mod NREQ, grant<=0, when either:
  - an accept makes beat_cnt==MAX_BURST, or
  - in_valid[g]==0.
- Backpressure stall (valid but not ready) does not end the burst and does not advance beat_cnt.
- Level tracking:
  - dec = fifo_rd_en && !fifo_empty, mirroring FIFO read acceptance.
  - level_next = level + accept - dec. Simultaneous accept and dec leaves level unchanged.
  - Saturate at 0 (a dec at level 0 is ignored) and at DEPTH.
  - A same-cycle read does not create space for a same-cycle accept; the check uses the current level.
- Full boundary: at level==DEPTH, or fifo_full==1, in_ready=0. A requester may hold valid indefinitely.
- err_cnt increments on each fifo_wr_err pulse and saturates at 255. It is nonzero only on integration error.
- Fairness: every requester holding valid is granted within (NREQ-1) bursts plus the arbitration cycles.
- NREQ wrap: rr_ptr wraps NREQ-1 -> 0.
- No combinational path from fifo_rd_en to in_ready.

Test Plan:
- Single requester: rst 2 cycles, then in_valid[1]=1 with data 0x11..0x16. Expect grant=0010 one cycle later; 4 writes 0x11-0x14 on consecutive cycles, each one cycle after accept; then 1 ARB cycle; regrant req1; 0x15, 0x16 follow; level=6.
- Round-robin: all four valid continuously, MAX_BURST=4. Expect grant order 0001,0010,0100,1000,0001; 4 writes per burst with 1 idle cycle between bursts.
- Full: no reads, req0 streams 20 beats. Expect exactly 16 fifo_wr_en pulses, level=16, in_ready[0]=0 while valid stays high, grant held, err_cnt=0.
- Full then drain: from level=16 pulse fifo_rd_en 1 cycle with fifo_empty=0. Expect level=15, and exactly one more beat accepted once fifo_full deasserts.
- Simultaneous: level=8, accept and dec in the same cycle. Expect level stays 8. A dec at level 0 with fifo_empty=1 leaves level at 0.
- Reset mid-burst: assert rst on beat 2 of a req2 burst. Expect next cycle grant=0, fifo_wr_en=0, level=0, rr_ptr=0; the first grant after reset goes to the lowest valid index.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one syncfifo write port among NREQ valid/ready requesters.
// Occupancy is tracked locally so a write is never issued while the FIFO's full flag lags.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4,
  parameter int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ*WIDTH-1:0] in_data,
  output logic [NREQ-1:0]       in_ready,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_wdata,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic                  fifo_rd_en,
  input  logic                  fifo_wr_err,
  output logic [NREQ-1:0]       grant,
  output logic [LVL_W-1:0]      level,
  output logic [7:0]            err_cnt
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [BC_W-1:0]  MAXB_L  = BC_W'(MAX_BURST);
  localparam logic [IDX_W:0]   NREQ_L  = (IDX_W + 1)'(NREQ);
  localparam logic [IDX_W-1:0] LAST_L  = IDX_W'(NREQ - 1);

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t             state_r, state_s;
  logic [NREQ-1:0]    grant_r, grant_s;
  logic [IDX_W-1:0]   owner_r, owner_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [IDX_W-1:0]   sel_s;
  logic               found_s;
  logic [IDX_W:0]     idx_s;
  logic [BC_W-1:0]    beat_cnt_r, beat_cnt_s;
  logic [LVL_W-1:0]   level_r, level_s;
  logic               wr_en_r, wr_en_s;
  logic [WIDTH-1:0]   wdata_r, wdata_s;
  logic [WIDTH-1:0]   owner_data_s;
  logic [7:0]         err_cnt_r, err_cnt_s;
  logic               owner_valid_s, space_s, accept_s, dec_s;

  function automatic logic [NREQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Round-robin search: first valid index starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    sel_s   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = {1'b0, rr_ptr_r} + (IDX_W + 1)'(k);
      if (idx_s >= NREQ_L) begin
        idx_s = idx_s - NREQ_L;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && in_valid[idx_s[IDX_W-1:0]]) begin
        found_s = 1'b1;
        sel_s   = idx_s[IDX_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Owner-side handshake; space uses the current level only, so in_ready never sees fifo_rd_en.
  always_comb begin
    owner_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_data_s = owner_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_r[i]}});
    end
    owner_valid_s = |(in_valid & grant_r);
    space_s       = (level_r < DEPTH_L) && !fifo_full && !rst;
    accept_s      = (state_r == ST_GRANT) && owner_valid_s && space_s;
    dec_s         = fifo_rd_en && !fifo_empty;
    if ((state_r == ST_GRANT) && space_s) begin
      in_ready = grant_r;
    end else begin
      in_ready = '0;
    end
  end

  // Arbitration FSM next state, burst accounting and write-port drive.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    owner_s    = owner_r;
    rr_ptr_s   = rr_ptr_r;
    beat_cnt_s = beat_cnt_r;
    wr_en_s    = 1'b0;
    wdata_s    = wdata_r;
    case (state_r)
      ST_ARB: begin
        if (found_s) begin
          state_s    = ST_GRANT;
          grant_s    = to_onehot(sel_s);
          owner_s    = sel_s;
          beat_cnt_s = '0;
        end else begin
          grant_s = '0;
        end
      end
      ST_GRANT: begin
        if (accept_s) begin
          wr_en_s    = 1'b1;
          wdata_s    = owner_data_s;
          beat_cnt_s = beat_cnt_r + BC_W'(1);
        end else begin
          wr_en_s = 1'b0;
        end
        // A stall (valid without ready) keeps the grant; only a full burst or dropped valid ends it.
        if ((accept_s && (beat_cnt_r + BC_W'(1) == MAXB_L)) || !owner_valid_s) begin
          state_s = ST_ARB;
          grant_s = '0;
          if (owner_r == LAST_L) begin
            rr_ptr_s = '0;
          end else begin
            rr_ptr_s = owner_r + IDX_W'(1);
          end
        end else begin
          state_s = ST_GRANT;
        end
      end
      default: begin
        state_s = ST_ARB;
        grant_s = '0;
      end
    endcase
  end

  // Occupancy and error-count next values, both saturating.
  always_comb begin
    if (accept_s && !dec_s) begin
      level_s = (level_r < DEPTH_L) ? level_r + LVL_W'(1) : level_r;
    end else if (dec_s && !accept_s) begin
      level_s = (level_r != '0) ? level_r - LVL_W'(1) : level_r;
    end else begin
      level_s = level_r;
    end
    if (fifo_wr_err && (err_cnt_r != 8'hFF)) begin
      err_cnt_s = err_cnt_r + 8'd1;
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_ARB;
      grant_r    <= '0;
      owner_r    <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
      level_r    <= '0;
      wr_en_r    <= 1'b0;
      wdata_r    <= '0;
      err_cnt_r  <= 8'd0;
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      owner_r    <= owner_s;
      rr_ptr_r   <= rr_ptr_s;
      beat_cnt_r <= beat_cnt_s;
      level_r    <= level_s;
      wr_en_r    <= wr_en_s;
      wdata_r    <= wdata_s;
      err_cnt_r  <= err_cnt_s;
    end
  end

  assign fifo_wr_en = wr_en_r;
  assign fifo_wdata = wdata_r;
  assign grant      = grant_r;
  assign level      = level_r;
  assign err_cnt    = err_cnt_r;

endmodule
